// File: rtl/cv32e40p_mult_iter.sv
// Iterative MUL/MULH/MULHSU/MULHU unit: one (XLEN+1)x(SLICE+1) signed partial product per cycle,
// accumulated over XLEN/SLICE cycles, with valid/ready handshakes on both sides and a flush kill.
module cv32e40p_mult_iter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SLICE = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int unsigned N    = XLEN / SLICE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PpW  = 2 * XLEN + 2;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
  logic                a_signed_q, a_signed_d, b_signed_q, b_signed_d, hi_sel_q, hi_sel_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic                last_slice;
  logic [XLEN-1:0]     b_shift;
  logic [SLICE:0]      bk;
  logic [XLEN:0]       ax;
  logic [PpW-1:0]      ax_w, bk_w, pp_w, pp_sh;

  assign last_slice = (cnt_q == CntW'(N - 1));

  // Both factors are sign-extended to a common width wide enough for the full product, so a
  // plain modular multiply yields the signed partial product.
  always_comb begin
    b_shift = b_q >> (SLICE * cnt_q);
    bk      = {b_signed_q & b_q[XLEN-1] & last_slice, b_shift[SLICE-1:0]};
    ax      = {a_signed_q & a_q[XLEN-1], a_q};
    ax_w    = {{(PpW - XLEN - 1){ax[XLEN]}}, ax};
    bk_w    = {{(PpW - SLICE - 1){bk[SLICE]}}, bk};
    pp_w    = ax_w * bk_w;
    pp_sh   = pp_w << (SLICE * cnt_q);
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    a_signed_d = a_signed_q;
    b_signed_d = b_signed_q;
    hi_sel_d   = hi_sel_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          a_d        = op_a_i;
          b_d        = op_b_i;
          a_signed_d = (op_i == 2'b01) || (op_i == 2'b10);
          b_signed_d = (op_i == 2'b01);
          hi_sel_d   = (op_i != 2'b00);
          acc_d      = '0;
          cnt_d      = '0;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        acc_d = acc_q + pp_sh[2*XLEN-1:0];
        cnt_d = cnt_q + 1'b1;
        if (last_slice) state_d = StDone;
      end
      StDone: begin
        if (ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Flush beats everything, including an accept in idle.
    if (flush_i) begin
      state_d = StIdle;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      a_signed_q <= 1'b0;
      b_signed_q <= 1'b0;
      hi_sel_q   <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      a_signed_q <= a_signed_d;
      b_signed_q <= b_signed_d;
      hi_sel_q   <= hi_sel_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ready_o  = (state_q == StIdle);
  assign valid_o  = (state_q == StDone);
  assign busy_o   = (state_q != StIdle);
  assign result_o = hi_sel_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];

endmodule

// File: tb/tb_cv32e40p_mult_iter.sv
// Directed and randomised checks of cv32e40p_mult_iter: results, latency, backpressure, flush
// and asynchronous reset.
module tb_cv32e40p_mult_iter;

  localparam int unsigned Xlen  = 32;
  localparam int unsigned Slice = 16;
  localparam int unsigned NCyc  = Xlen / Slice;

  logic            clk;
  logic            rst_n;
  logic            valid_i;
  logic            ready_o;
  logic [1:0]      op_i;
  logic [Xlen-1:0] op_a_i;
  logic [Xlen-1:0] op_b_i;
  logic            flush_i;
  logic            valid_o;
  logic            ready_i;
  logic [Xlen-1:0] result_o;
  logic            busy_o;

  int n_vec;
  int n_err;

  cv32e40p_mult_iter #(
    .XLEN  (Xlen),
    .SLICE (Slice)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic        as, bs;
    as = (op == 2'b01) || (op == 2'b10);
    bs = (op == 2'b01);
    ea = {{32{as & a[31]}}, a};
    eb = {{32{bs & b[31]}}, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, check latency and result, optionally stall the consumer, then handshake.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int hold);
    int lat;
    valid_i = 1'b1;
    op_i    = op;
    op_a_i  = a;
    op_b_i  = b;
    tick();
    valid_i = 1'b0;
    op_a_i  = $urandom;
    op_b_i  = $urandom;
    op_i    = 2'($urandom_range(0, 3));
    check({tag, "_accept"}, {63'd0, busy_o}, 64'd1);
    lat = 0;
    while (!valid_o && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(NCyc));
    check({tag, "_res"}, {32'd0, result_o}, {32'd0, exp});
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold"}, {30'd0, valid_o, ready_o, result_o}, {30'd0, 2'b10, exp});
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check({tag, "_idle"}, {62'd0, ready_o, valid_o}, 64'd2);
  endtask

  initial begin
    logic        seen_valid;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    valid_i = 1'b0;
    op_i    = 2'b00;
    op_a_i  = '0;
    op_b_i  = '0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    #23;
    check("rst_outs", {29'd0, ready_o, valid_o, busy_o, result_o}, {29'd0, 3'b100, 32'd0});
    rst_n = 1'b1;
    tick();

    do_op("mul_7xm3",   2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0);
    do_op("mulh_min",   2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 0);
    do_op("mulhu_max",  2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    do_op("mulhsu_m1",  2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_op("mul_2p32",   2'b00, 32'h00010000, 32'h00010000, 32'h00000000, 0);
    do_op("mulh_2p32",  2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 0);
    do_op("mulh_m1m1",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0);
    do_op("mulhsu_m7",  2'b10, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 0);
    do_op("mul_stall",  2'b00, 32'd3,        32'd5,        32'h0000000F, 5);
    // Back-to-back accept right after the handshake cycle.
    do_op("mulhu_next", 2'b11, 32'h12345678, 32'h00000010, 32'h00000001, 0);

    // Flush during the first busy cycle.
    valid_i = 1'b1;
    op_i    = 2'b01;
    op_a_i  = 32'h7FFFFFFF;
    op_b_i  = 32'h7FFFFFFF;
    tick();
    valid_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_ready", {62'd0, ready_o, valid_o}, 64'd2);
    seen_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen_valid |= valid_o;
      tick();
    end
    check("flush_novalid", {63'd0, seen_valid}, 64'd0);
    do_op("mulhu_3x5",  2'b11, 32'd3, 32'd5, 32'h00000000, 0);
    do_op("mul_3x5",    2'b00, 32'd3, 32'd5, 32'h0000000F, 0);

    // Flush in idle wins over a valid request.
    valid_i = 1'b1;
    flush_i = 1'b1;
    tick();
    valid_i = 1'b0;
    flush_i = 1'b0;
    check("flush_idle", {62'd0, busy_o, ready_o}, 64'd1);

    // Asynchronous reset mid-operation.
    valid_i = 1'b1;
    op_i    = 2'b01;
    op_a_i  = 32'h80000000;
    op_b_i  = 32'h80000000;
    tick();
    valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid", {29'd0, ready_o, valid_o, busy_o, result_o}, {29'd0, 3'b100, 32'd0});
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_after", {62'd0, valid_o, busy_o}, 64'd0);
    do_op("post_rst",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);

    for (int i = 0; i < 200; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = (i % 7 == 0) ? 32'h80000000 : 32'($urandom);
      rb  = (i % 5 == 0) ? 32'hFFFFFFFF : 32'($urandom);
      do_op("rand", rop, ra, rb, ref_mul(rop, ra, rb), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cv32e40p_mult_iter.md
# cv32e40p_mult_iter

Parametrised iterative multiplier for the EX stage. It computes the MUL/MULH/MULHSU/MULHU results over XLEN-bit operands with one (XLEN+1)×(SLICE+1) signed multiplier, consuming one SLICE-bit slice of operand B per cycle. It replaces the fixed 32-bit, fixed 4-step MULH sequencer with a width- and latency-configurable datapath. Both ends use a valid/ready handshake, and a flush input supports pipeline kills.

## Interface
- XLEN, 32: operand and result width.
- SLICE, 16: bits of B consumed per cycle. Legal values: XLEN mod SLICE == 0 and SLICE ≥ 1. N = XLEN/SLICE compute cycles.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- valid_i  in  1  request valid
- ready_o  out  1  unit can accept a request
- op_i  in  2  00 MUL (low half), 01 MULH (s×s), 10 MULHSU (A signed, B unsigned), 11 MULHU (u×u)
- op_a_i  in  XLEN  multiplicand A
- op_b_i  in  XLEN  multiplier B
- flush_i  in  1  abort the in-flight operation
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts the result
- result_o  out  XLEN  result
- busy_o  out  1  state ≠ IDLE

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: ready_o=1. When valid_i=1, the unit accepts the request:
  - latches A, B, a_signed = (op ∈ {MULH, MULHSU}), b_signed = (op == MULH), and hi_sel = (op ≠ MUL);
  - clears acc (2·XLEN bits) and cnt;
  - moves to BUSY.
- BUSY, slice k = cnt:
  - bk = B[k·SLICE +: SLICE], extended to SLICE+1 bits. The extension bit is b_signed & B[XLEN-1] only when k = N-1; otherwise it is 0.
  - ax = A extended to XLEN+1 bits with a_signed & A[XLEN-1].
  - pp = signed(ax)·signed(bk), XLEN+SLICE+2 bits. It is sign-extended to 2·XLEN bits and shifted left by k·SLICE.
  - acc ← acc + shifted pp, modulo 2^(2·XLEN). The modulo is exact because the true product fits in 2·XLEN bits.
  - cnt increments. When cnt == N-1, the state moves to DONE.
- DONE: valid_o=1. result_o = hi_sel ? acc[2·XLEN-1:XLEN] : acc[XLEN-1:0]. When ready_i=1, the state moves to IDLE. Otherwise the unit holds, with result_o stable.
- ready_o=1 only in IDLE; there is no accept during BUSY or DONE.
- flush_i=1 in any state: the next state is IDLE and valid_o is 0 in the following cycle. In IDLE, flush_i has priority over valid_i; no accept occurs.
- SLICE == XLEN (N=1): BUSY lasts exactly one cycle; there is no special casing.
- cnt width: max(1, clog2(N)).

## Timing
- Reset values: state IDLE, ready_o=1, valid_o=0, busy_o=0, result_o=0, acc=0, cnt=0.
- Accept occurs at the rising edge where valid_i & ready_o & ~flush_i.
- BUSY lasts exactly N cycles. valid_o rises on the N-th rising edge after the accept edge (latency N).
- result_o is driven from registers, with no combinational path from inputs to outputs.
- ready_o and valid_o depend only on state. They have no combinational path from valid_i, ready_i or flush_i.
- The earliest next accept is 1 cycle after the result handshake (DONE → IDLE → accept). Throughput is 1 result per N+2 cycles without backpressure.
- Operand inputs may change after the accept edge without effect.
- Reset asserted mid-operation returns the unit immediately to the reset values. No valid_o pulse follows.

## Test plan
- XLEN=32, SLICE=16: MUL, A=7, B=0xFFFFFFFD (-3) → result_o=0xFFFFFFEB, with valid_o exactly 2 cycles after accept.
- MULH A=B=0x80000000 → 0x40000000. MULHU A=B=0xFFFFFFFF → 0xFFFFFFFE. MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF → 0xFFFFFFFF.
- Hold ready_i=0 for 5 cycles in DONE → valid_o, result_o and ready_o=0 stay stable. ready_i=1 → IDLE on the next edge, and a new request is accepted on the edge after that.
- Assert flush_i in BUSY cycle 1 → valid_o never rises and ready_o=1 on the next cycle. A following MULHU 3×5 returns 0x00000000; as MUL it returns 0x0000000F.
- SLICE=8 and SLICE=32 builds: the same vectors give identical results, with latency 4 and 1 respectively. Run 10k random op/A/B against a 64-bit reference product with random ready_i, flush_i and valid_i.
- Assert rst_n low mid-BUSY → all outputs at reset values immediately. After release, the next request completes correctly.
